hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting beside the datapath and driving the per-stage stall/flush enables and the Execute-stage forwarding muxes. It resolves RAW hazards by forwarding from Memory/Writeback and inserts a configurable number of load-use bubbles through a small FSM. It flushes on taken branches and jumps. It freezes the whole pipeline while data memory reports busy, and flags a watchdog error if that wait exceeds a bound.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_ctrl_forward_sel.sv | 18 +
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;
    typedef enum logic {
        RUN    = 1'b0,
        LSTALL = 1'b1
    } hz_state_t;
    localparam int LOAD_LAT_MIN = 1;
    localparam int LOAD_LAT_MAX = 4;
endpackage

// File: rtl/hazard_ctrl_forward_sel.sv
// forward_sel: Execute-operand bypass select; Memory beats Writeback, x0 never forwarded.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rd_m,
    input  logic [REG_W-1:0] i_rd_w,
    input  logic             i_we_m,
    input  logic             i_we_w,
    output logic [1:0]       o_sel
);
    logic w_hit_m, w_hit_w;
    assign w_hit_m = i_we_m && i_rd_m != '0 && i_rd_m == i_rs;
    assign w_hit_w = i_we_w && i_rd_w != '0 && i_rd_w == i_rs;
    assign o_sel   = w_hit_m ? FWD_MEM : w_hit_w ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use bubbles, branch flush, memory freeze and wait watchdog.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int MAX_WAIT = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RdE,
    input  logic [REG_W-1:0] RdM,
    input  logic [REG_W-1:0] RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReadE,
    input  logic             branchE,
    input  logic             memBusy,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             waitErr
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
`endif
);
    localparam int LAT    = LOAD_LAT < LOAD_LAT_MIN ? LOAD_LAT_MIN :
                            LOAD_LAT > LOAD_LAT_MAX ? LOAD_LAT_MAX : LOAD_LAT;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    hz_state_t         r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic              r_wait_err;
    logic              w_lu, w_bubble;
    logic [1:0]        w_fa, w_fb;

    forward_sel #(.REG_W(REG_W)) u_fwd_a (
        .i_rs(Rs1E), .i_rd_m(RdM), .i_rd_w(RdW),
        .i_we_m(RegWriteM), .i_we_w(RegWriteW), .o_sel(w_fa)
    );
    forward_sel #(.REG_W(REG_W)) u_fwd_b (
        .i_rs(Rs2E), .i_rd_m(RdM), .i_rd_w(RdW),
        .i_we_m(RegWriteM), .i_we_w(RegWriteW), .o_sel(w_fb)
    );

    assign w_lu     = MemReadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
    assign w_bubble = r_state == LSTALL || w_lu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // the count holds the bubbles still owed after the current one
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!memBusy) begin
            if (branchE) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end else if (r_state == LSTALL) begin
                w_cnt_nxt   = r_cnt - 3'd1;
                w_state_nxt = r_cnt == 3'd1 ? RUN : LSTALL;
            end else if (w_lu && LAT > 1) begin
                w_state_nxt = LSTALL;
                w_cnt_nxt   = 3'(LAT - 1);
            end
        end
    end

    always_comb begin
        forwardAE = rst ? FWD_RF : w_fa;
        forwardBE = rst ? FWD_RF : w_fb;
        stallF    = !rst && (memBusy || (!branchE && w_bubble));
        stallD    = stallF;
        stallE    = !rst && memBusy;
        stallM    = stallE;
        flushD    = rst || (!memBusy && branchE);
        flushE    = rst || (!memBusy && (branchE || w_bubble));
    end

    assign w_wait_nxt = !memBusy ? '0 :
                        r_wait == WAIT_W'(MAX_WAIT) ? r_wait : r_wait + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait     <= '0;
            r_wait_err <= 1'b0;
        end else begin
            r_wait     <= w_wait_nxt;
            r_wait_err <= r_wait_err || w_wait_nxt == WAIT_W'(MAX_WAIT);
        end
    end

    assign waitErr = r_wait_err;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(stallF);
            r_flush_cnt <= r_flush_cnt + CNT_W'(flushD || flushE);
        end
    end
    assign stallCnt = r_stall_cnt;
    assign flushCnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vectors with a queued scoreboard for hazard_ctrl.
// Instance a: LOAD_LAT=3, MAX_WAIT=4; instance b: LOAD_LAT=1.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteM, RegWriteW, MemReadE, branchE, memBusy;

    logic [1:0] a_fa, a_fb, b_fa, b_fb;
    logic a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_we;
    logic b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_we;
    logic [31:0] a_sc, a_fc, b_sc, b_fc;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .MAX_WAIT(4), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .branchE(branchE), .memBusy(memBusy),
        .forwardAE(a_fa), .forwardBE(a_fb), .stallF(a_sf), .stallD(a_sd), .stallE(a_se),
        .stallM(a_sm), .flushD(a_fd), .flushE(a_fe), .waitErr(a_we)
`ifdef HAZARD_PERF_CNT_EN
        , .stallCnt(a_sc), .flushCnt(a_fc)
`endif
    );

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .MAX_WAIT(255), .CNT_W(32)) u_b (
        .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemReadE(MemReadE), .branchE(branchE), .memBusy(memBusy),
        .forwardAE(b_fa), .forwardBE(b_fb), .stallF(b_sf), .stallD(b_sd), .stallE(b_se),
        .stallM(b_sm), .flushD(b_fd), .flushE(b_fe), .waitErr(b_we)
`ifdef HAZARD_PERF_CNT_EN
        , .stallCnt(b_sc), .flushCnt(b_fc)
`endif
    );

`ifndef HAZARD_PERF_CNT_EN
    assign a_sc = '0;
    assign a_fc = '0;
    assign b_sc = '0;
    assign b_fc = '0;
`endif

    typedef struct {
        int          id;
        bit          d;
        logic [1:0]  fa, fb;
        logic [3:0]  st;
        logic [1:0]  fl;
        logic        we;
        bit          cc;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_fail = 0;
    int n_step = 0;

    task automatic chk(input string n, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0h expected %0h", id, n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("forwardAE", e.id, 32'(e.d ? b_fa : a_fa), 32'(e.fa));
            chk("forwardBE", e.id, 32'(e.d ? b_fb : a_fb), 32'(e.fb));
            chk("stallFDEM", e.id, 32'(e.d ? {b_sf, b_sd, b_se, b_sm} : {a_sf, a_sd, a_se, a_sm}), 32'(e.st));
            chk("flushDE", e.id, 32'(e.d ? {b_fd, b_fe} : {a_fd, a_fe}), 32'(e.fl));
            chk("waitErr", e.id, 32'(e.d ? b_we : a_we), 32'(e.we));
`ifdef HAZARD_PERF_CNT_EN
            if (e.cc) begin
                chk("stallCnt", e.id, e.d ? b_sc : a_sc, e.sc);
                chk("flushCnt", e.id, e.d ? b_fc : a_fc, e.fc);
            end
`endif
        end
    end

    task automatic step(input bit d, input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] st,
                        input logic [1:0] fl, input logic we, input bit cc = 1'b0,
                        input logic [31:0] sc = 0, input logic [31:0] fc = 0);
        exp_t e;
        e.id = n_step; e.d = d; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl; e.we = we;
        e.cc = cc; e.sc = sc; e.fc = fc;
        q.push_back(e);
        n_step++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, MemReadE, branchE, memBusy} = '0;
    endtask

    task automatic load_use();
        clr();
        MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        @(posedge clk);
        #1;
        // reset: forwarding and load-use inputs active but outputs forced
        RdM = 5'd5; RegWriteM = 1'b1; Rs1E = 5'd5; MemReadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b11, 0, 1, 0, 0);
        rst = 1'b0;
        clr();
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd6;
        step(0, 2'b10, 2'b00, 4'b0000, 2'b00, 0);
        RegWriteM = 1'b0; Rs2E = 5'd5;
        step(0, 2'b01, 2'b01, 4'b0000, 2'b00, 0);
        RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b00, 0);
        RdM = 5'd3; RdW = 5'd4; Rs1E = 5'd4; Rs2E = 5'd3;
        step(0, 2'b01, 2'b10, 4'b0000, 2'b00, 0);
        // LOAD_LAT=3 with a 2-cycle freeze in the middle
        load_use();
        step(0, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        clr();
        step(0, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        memBusy = 1'b1;
        step(0, 2'b00, 2'b00, 4'b1111, 2'b00, 0);
        step(0, 2'b00, 2'b00, 4'b1111, 2'b00, 0);
        memBusy = 1'b0;
        step(0, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        step(0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 1, 5, 3);
        load_use();
        branchE = 1'b1;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b11, 0);
        clr();
        step(0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 1, 5, 4);
        // counters: three bubbles plus one branch from a fresh reset
        rst = 1'b1;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b11, 0, 1, 0, 0);
        rst = 1'b0;
        load_use();
        step(0, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        clr();
        step(0, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        step(0, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        branchE = 1'b1;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b11, 0);
        clr();
        step(0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 1, 3, 4);
        // reset in the middle of LSTALL drops the remaining bubbles
        load_use();
        step(0, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        clr();
        rst = 1'b1;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b11, 0, 1, 0, 0);
        rst = 1'b0;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b00, 0, 1, 0, 0);
        // watchdog, MAX_WAIT=4
        memBusy = 1'b1;
        repeat (4) step(0, 2'b00, 2'b00, 4'b1111, 2'b00, 0);
        memBusy = 1'b0;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b00, 1);
        step(0, 2'b00, 2'b00, 4'b0000, 2'b00, 1);
        rst = 1'b1;
        step(0, 2'b00, 2'b00, 4'b0000, 2'b11, 0);
        rst = 1'b0;
        // LOAD_LAT=1 instance
        load_use();
        step(1, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        clr();
        step(1, 2'b00, 2'b00, 4'b0000, 2'b00, 0);
        MemReadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0;
        step(1, 2'b00, 2'b00, 4'b0000, 2'b00, 0);
        RdE = 5'd9; Rs1D = 5'd9;
        step(1, 2'b00, 2'b00, 4'b1100, 2'b01, 0);
        clr();
        step(1, 2'b00, 2'b00, 4'b0000, 2'b00, 0);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
